// File: rtl/dmem_responder.sv
// Single-cycle data memory responder: word RAM, GPIO register, TX byte FIFO and an
// optional 64-bit machine timer that is built only when DMEM_TIMER_EN is defined.
module dmem_responder #(
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] aluresultM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic [31:0] gpio_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [3:0] {
    REG_GPIO_OUT    = 4'h0,
    REG_TX_DATA     = 4'h1,
    REG_TX_STATUS   = 4'h2,
    REG_MTIME_LO    = 4'h4,
    REG_MTIME_HI    = 4'h5,
    REG_MTIMECMP_LO = 4'h6,
    REG_MTIMECMP_HI = 4'h7
  } mmio_reg_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          is_mmio;
  logic [3:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic          gpio_we;
  logic          tx_push;
  logic          status_we;
  logic          unused_addr_bits;

  assign is_mmio   = aluresultM[31];
  assign mmio_off  = aluresultM[5:2];
  assign ram_idx   = aluresultM[AW+1:2];
  assign ram_we    = mem_write & ~is_mmio;
  assign gpio_we   = mem_write & is_mmio & (mmio_off == REG_GPIO_OUT);
  assign tx_push   = mem_write & is_mmio & (mmio_off == REG_TX_DATA);
  assign status_we = mem_write & is_mmio & (mmio_off == REG_TX_STATUS);

  // Byte offset and the RAM alias bits never take part in decode.
  assign unused_addr_bits = ^{aluresultM[30:AW+2], aluresultM[1:0]};

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [DEPTH];

  // NOTE: storage arrays carry no reset; a reset would force them into flops and
  // software owns their contents anyway.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= writedataM;
  end

  // ---------------------------------------------------------------------------
  // GPIO output register
  // ---------------------------------------------------------------------------
  logic [31:0] gpio_q;
  logic [31:0] gpio_d;

  always_comb begin
    gpio_d = gpio_q;
    if (gpio_we) gpio_d = writedataM;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gpio_q <= '0;
    else        gpio_q <= gpio_d;
  end

  assign gpio_out = gpio_q;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          tx_pop;
  logic          push_ok;
  logic [31:0]   tx_status;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign tx_pop     = ~fifo_empty & tx_ready;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push_ok    = tx_push & (~fifo_full | tx_pop);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (tx_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_ok, tx_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (status_we)               ovf_d = 1'b0;
    else if (tx_push & ~push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= writedataM[7:0];
  end

  assign tx_valid  = ~fifo_empty;
  // Storage is not cleared on reset, so the head byte is masked while empty.
  assign tx_data   = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign tx_status = {25'd0, ovf_q, 4'(count_q), fifo_empty, fifo_full};

  // ---------------------------------------------------------------------------
  // Machine timer
  // ---------------------------------------------------------------------------
  logic [31:0] timer_rdata;

`ifdef DMEM_TIMER_EN
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q, irq_d;

  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (mem_write & is_mmio) begin
      unique case (mmio_off)
        REG_MTIME_LO:    mtime_d    = {mtime_q[63:32], writedataM};
        REG_MTIME_HI:    mtime_d    = {writedataM, mtime_q[31:0]};
        REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], writedataM};
        REG_MTIMECMP_HI: mtimecmp_d = {writedataM, mtimecmp_q[31:0]};
        default:         mtimecmp_d = mtimecmp_q;
      endcase
    end
    irq_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    unique case (mmio_off[1:0])
      2'd0:    timer_rdata = mtime_q[31:0];
      2'd1:    timer_rdata = mtime_q[63:32];
      2'd2:    timer_rdata = mtimecmp_q[31:0];
      default: timer_rdata = mtimecmp_q[63:32];
    endcase
  end

  assign timer_irq = irq_q;
`else
  assign timer_rdata = 32'd0;
  assign timer_irq   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Load data, zero latency
  // ---------------------------------------------------------------------------
  always_comb begin
    readdataM = 32'd0;
    if (!is_mmio) begin
      readdataM = ram_q[ram_idx];
    end else begin
      unique case (mmio_off)
        REG_GPIO_OUT:    readdataM = gpio_q;
        REG_TX_STATUS:   readdataM = tx_status;
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI: readdataM = timer_rdata;
        default:         readdataM = 32'd0;
      endcase
    end
  end

endmodule
